// File: rtl/join_stage_pkg.sv
// Shared encodings for the two-operand join stage: slot and output state
// machines plus the default operand width.
package join_stage_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ACK   = 2'd1,
    S_FULL  = 2'd2
  } slot_state_t;

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_REQ  = 2'd1,
    O_RTZ  = 2'd2
  } out_state_t;

endpackage

// File: rtl/join_slot.sv
// One operand slot: accepts a four-phase token, holds it until the joined
// output has been released downstream.
module join_slot
  import join_stage_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         mr_n,
  input  logic         send_in,
  input  logic [W-1:0] data_in,
  input  logic         rel,
  output logic         ack_out,
  output logic         full,
  output logic [W-1:0] data
);

  slot_state_t state, state_next;
  logic        capture;
  logic        ack_q;
  logic [W-1:0] data_q;

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      S_EMPTY: begin
        if (send_in) begin
          state_next = S_ACK;
          capture    = 1'b1;
        end
      end
      S_ACK: begin
        if (!send_in) state_next = S_FULL;
      end
      // A request arriving on the release edge is deliberately left for a
      // later edge: only EMPTY can capture.
      S_FULL: begin
        if (rel) state_next = S_EMPTY;
      end
      default: state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!mr_n) begin
      state  <= S_EMPTY;
      ack_q  <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_next;
      ack_q <= (state_next == S_ACK);
      if (capture) data_q <= data_in;
    end
  end

  assign ack_out = ack_q;
  assign full    = (state == S_FULL);
  assign data    = data_q;

endmodule

// File: rtl/join_stage.sv
// Two-input four-phase join: waits for both operand slots to fill, emits
// {A,B} downstream and frees both slots once the output handshake completes.
module join_stage
  import join_stage_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           MR_n,
  input  logic           Send_in_a,
  input  logic [W-1:0]   Data_in_a,
  output logic           Ack_out_a,
  input  logic           Send_in_b,
  input  logic [W-1:0]   Data_in_b,
  output logic           Ack_out_b,
  output logic           Send_out,
  output logic [2*W-1:0] Data_out,
  input  logic           Ack_in,
  output logic [7:0]     Join_cnt
);

  out_state_t    state, state_next;
  logic          full_a, full_b;
  logic [W-1:0]  data_a, data_b;
  logic          rel;
  logic          load;
  logic          send_q;
  logic [2*W-1:0] data_q;
  logic [7:0]    cnt_q;

  join_slot #(.W(W)) u_slot_a (
    .clk     (clk),
    .mr_n    (MR_n),
    .send_in (Send_in_a),
    .data_in (Data_in_a),
    .rel     (rel),
    .ack_out (Ack_out_a),
    .full    (full_a),
    .data    (data_a)
  );

  join_slot #(.W(W)) u_slot_b (
    .clk     (clk),
    .mr_n    (MR_n),
    .send_in (Send_in_b),
    .data_in (Data_in_b),
    .rel     (rel),
    .ack_out (Ack_out_b),
    .full    (full_b),
    .data    (data_b)
  );

  always_comb begin
    state_next = state;
    rel        = 1'b0;
    load       = 1'b0;
    case (state)
      O_IDLE: begin
        if (full_a && full_b) begin
          state_next = O_REQ;
          load       = 1'b1;
        end
      end
      O_REQ: begin
        if (Ack_in) state_next = O_RTZ;
      end
      // Return-to-zero completes the token; both slots free on this edge.
      O_RTZ: begin
        if (!Ack_in) begin
          state_next = O_IDLE;
          rel        = 1'b1;
        end
      end
      default: state_next = O_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!MR_n) begin
      state  <= O_IDLE;
      send_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= 8'd0;
    end else begin
      state  <= state_next;
      send_q <= (state_next == O_REQ);
      if (load) data_q <= {data_a, data_b};
      if (rel)  cnt_q  <= cnt_q + 8'd1;
    end
  end

  assign Send_out = send_q;
  assign Data_out = data_q;
  assign Join_cnt = cnt_q;

endmodule

// File: tb/tb_join_stage.sv
// Directed bench for join_stage: reset, single joins, starved operand,
// stuck downstream acknowledge, counter wrap and mid-handshake reset.
module tb_join_stage;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           MR_n;
  logic           Send_in_a, Send_in_b, Ack_in;
  logic [W-1:0]   Data_in_a, Data_in_b;
  logic           Ack_out_a, Ack_out_b, Send_out;
  logic [2*W-1:0] Data_out;
  logic [7:0]     Join_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_cnt;

  join_stage #(.W(W)) dut (
    .clk       (clk),
    .MR_n      (MR_n),
    .Send_in_a (Send_in_a),
    .Data_in_a (Data_in_a),
    .Ack_out_a (Ack_out_a),
    .Send_in_b (Send_in_b),
    .Data_in_b (Data_in_b),
    .Ack_out_b (Ack_out_b),
    .Send_out  (Send_out),
    .Data_out  (Data_out),
    .Ack_in    (Ack_in),
    .Join_cnt  (Join_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [W-1:0] d);
    Send_in_a = 1'b1;
    Data_in_a = d;
    tick();
    check("ack_a_rise", 32'(Ack_out_a), 32'd1);
    Send_in_a = 1'b0;
    Data_in_a = 8'hxx;
    tick();
    check("ack_a_fall", 32'(Ack_out_a), 32'd0);
  endtask

  task automatic send_b(input logic [W-1:0] d);
    Send_in_b = 1'b1;
    Data_in_b = d;
    tick();
    check("ack_b_rise", 32'(Ack_out_b), 32'd1);
    Send_in_b = 1'b0;
    Data_in_b = 8'hxx;
    tick();
    check("ack_b_fall", 32'(Ack_out_b), 32'd0);
  endtask

  // Called right after the second slot has filled.
  task automatic drain(input logic [2*W-1:0] exp_data, input int stuck);
    tick();
    check("send_out_rise", 32'(Send_out), 32'd1);
    check("data_out", 32'(Data_out), 32'(exp_data));
    tick();
    check("send_out_hold", 32'(Send_out), 32'd1);
    Ack_in = 1'b1;
    tick();
    check("send_out_rtz", 32'(Send_out), 32'd0);
    for (int i = 0; i < stuck; i++) begin
      tick();
      check("rtz_send_low", 32'(Send_out), 32'd0);
      check("rtz_no_release", 32'(Join_cnt), 32'(exp_cnt));
      check("rtz_data_held", 32'(Data_out), 32'(exp_data));
    end
    Ack_in = 1'b0;
    tick();
    exp_cnt = exp_cnt + 8'd1;
    check("join_cnt", 32'(Join_cnt), 32'(exp_cnt));
    check("send_out_idle", 32'(Send_out), 32'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    MR_n = 1'b0; Send_in_a = 1'b0; Send_in_b = 1'b0; Ack_in = 1'b0;
    Data_in_a = '0; Data_in_b = '0;
    exp_cnt = 8'd0;

    // Reset for three cycles, then hold.
    repeat (3) tick();
    MR_n = 1'b1;
    tick();
    check("rst_ack_a", 32'(Ack_out_a), 32'd0);
    check("rst_ack_b", 32'(Ack_out_b), 32'd0);
    check("rst_send", 32'(Send_out), 32'd0);
    check("rst_data", 32'(Data_out), 32'd0);
    check("rst_cnt", 32'(Join_cnt), 32'd0);

    // Acknowledge from downstream while idle has no effect.
    Ack_in = 1'b1;
    repeat (3) tick();
    check("idle_ack_send", 32'(Send_out), 32'd0);
    check("idle_ack_cnt", 32'(Join_cnt), 32'd0);
    Ack_in = 1'b0;
    tick();

    // Basic join A=0x12, B=0x34.
    send_a(8'h12);
    send_b(8'h34);
    drain(16'h1234, 0);

    // A only: nothing goes downstream; second A request waits for release.
    send_a(8'h55);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("a_only_send", 32'(Send_out), 32'd0);
    end
    Send_in_a = 1'b1;
    Data_in_a = 8'h66;
    repeat (3) tick();
    check("a_full_ignored", 32'(Ack_out_a), 32'd0);
    send_b(8'h77);
    check("a_full_ignored2", 32'(Ack_out_a), 32'd0);
    drain(16'h5577, 0);
    check("a_no_capture_on_release", 32'(Ack_out_a), 32'd0);
    tick();
    check("a_second_capture", 32'(Ack_out_a), 32'd1);
    Send_in_a = 1'b0;
    tick();
    check("a_second_full", 32'(Ack_out_a), 32'd0);
    send_b(8'h88);
    drain(16'h6688, 0);

    // Downstream acknowledge stuck high for ten cycles.
    send_a(8'hA5);
    send_b(8'h3C);
    drain(16'hA53C, 10);

    // Reset while a token is being offered downstream.
    send_a(8'hDE);
    send_b(8'hAD);
    tick();
    check("pre_rst_send", 32'(Send_out), 32'd1);
    MR_n = 1'b0;
    tick();
    MR_n = 1'b1;
    exp_cnt = 8'd0;
    check("mid_rst_send", 32'(Send_out), 32'd0);
    check("mid_rst_data", 32'(Data_out), 32'd0);
    check("mid_rst_cnt", 32'(Join_cnt), 32'd0);
    check("mid_rst_ack_a", 32'(Ack_out_a), 32'd0);
    send_a(8'h12);
    send_b(8'h34);
    drain(16'h1234, 0);

    // 256 back-to-back joins from a fresh reset: counter wraps to zero.
    MR_n = 1'b0;
    tick();
    MR_n = 1'b1;
    exp_cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      b = 8'(i) ^ 8'h5A;
      send_a(a);
      send_b(b);
      drain({a, b}, 0);
    end
    check("wrap_cnt_zero", 32'(Join_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
